input_ctrl: RTL and testbench

INPUT_CTRL -- requirements
Module: input_ctrl

---
 rtl/input_ctrl_if.sv | 31 +++
 rtl/input_ctrl.sv | 99 +++++++++
 tb/tb_input_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/input_ctrl_if.sv
// Link/output-controller handshake bundle for input_ctrl.
//   din_vld, din    : link packet offer (link -> input_ctrl)
//   din_rdy         : input_ctrl can take the packet this cycle
//   req_0, req_1    : request to output controller 0 / 1
//   gnt_0, gnt_1    : same-cycle grant from output controller 0 / 1
//   dout            : packet offered to the output controllers
// master = link/output-controller side, slave = input_ctrl.
interface input_ctrl_if #(
  parameter int unsigned DATA_W = 64
);

  logic              din_vld;
  logic [DATA_W-1:0] din;
  logic              din_rdy;
  logic              req_0;
  logic              req_1;
  logic              gnt_0;
  logic              gnt_1;
  logic [DATA_W-1:0] dout;

  modport master (
    output din_vld, din, gnt_0, gnt_1,
    input  din_rdy, req_0, req_1, dout
  );

  modport slave (
    input  din_vld, din, gnt_0, gnt_1,
    output din_rdy, req_0, req_1, dout
  );

endinterface

// File: rtl/input_ctrl.sv
// Two-buffer ping-pong input controller for a 2-port switch.
// polarity selects which buffer is written (w = polarity) and which is
// offered to the output controllers (r = ~polarity). The route bit of
// the read-side packet selects req_0 or req_1; a matching grant pops it.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   polarity   : ping-pong phase select
//   bus        : handshake bundle (input_ctrl_if.slave)
//   in_cnt     : packets accepted from the link (wraps)
//   out_cnt    : packets forwarded (wraps)
//   stall_cnt  : cycles the current request has waited (saturates)
module input_ctrl #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ROUTE_BIT = 63
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           polarity,
  input_ctrl_if.slave    bus,
  output logic [15:0]    in_cnt,
  output logic [15:0]    out_cnt,
  output logic [7:0]     stall_cnt
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STALL_W = 8;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [DATA_W-1:0] pkt_buf [2];
  logic [1:0]        full;

  logic w_idx;
  logic r_idx;
  logic accept;
  logic pop;
  logic rd_full;
  logic rd_route;

  assign w_idx = polarity;
  assign r_idx = ~polarity;

  // Handshake decode; everything is gated by rst so nothing is visible
  // before the first reset edge clears the full flags.
  always_comb begin
    bus.din_rdy = 1'b0;
    bus.req_0   = 1'b0;
    bus.req_1   = 1'b0;
    bus.dout    = '0;
    accept      = 1'b0;
    pop         = 1'b0;
    rd_full     = full[r_idx];
    rd_route    = pkt_buf[r_idx][ROUTE_BIT];
    if (rst) begin
      bus.din_rdy = ~full[w_idx];
      bus.req_0   = rd_full & ~rd_route;
      bus.req_1   = rd_full &  rd_route;
      if (rd_full) begin
        bus.dout = pkt_buf[r_idx];
      end
      accept = bus.din_vld & bus.din_rdy;
      pop    = (bus.req_0 & bus.gnt_0) | (bus.req_1 & bus.gnt_1);
    end
  end

  // Packet storage; contents are qualified by the full flags, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pkt_buf[w_idx] <= bus.din;
    end
  end

  // Full flags and counters. Accept and pop always hit different buffers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full      <= 2'b00;
      in_cnt    <= '0;
      out_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        full[w_idx] <= 1'b1;
        in_cnt      <= in_cnt + CNT_W'(1);
      end
      if (pop) begin
        full[r_idx] <= 1'b0;
        out_cnt     <= out_cnt + CNT_W'(1);
      end
      if ((bus.req_0 | bus.req_1) && !pop) begin
        if (stall_cnt != STALL_MAX) begin
          stall_cnt <= stall_cnt + STALL_W'(1);
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_input_ctrl.sv
// Self-checking bench for input_ctrl: directed vector table plus
// hand-written sequences for stall saturation, reset with full buffers
// and a long counter-wrapping stream with a packet scoreboard.
module tb_input_ctrl;

  logic        clk;
  logic        rst;
  logic        polarity;
  logic [15:0] in_cnt;
  logic [15:0] out_cnt;
  logic [7:0]  stall_cnt;

  int checks;
  int failures;

  input_ctrl_if #(.DATA_W(64)) bus ();

  input_ctrl #(.DATA_W(64), .ROUTE_BIT(63)) dut (
    .clk       (clk),
    .rst       (rst),
    .polarity  (polarity),
    .bus       (bus.slave),
    .in_cnt    (in_cnt),
    .out_cnt   (out_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        p;
    logic        v;
    logic [63:0] d;
    logic        g0;
    logic        g1;
    logic        e_rdy;
    logic        e_r0;
    logic        e_r1;
    logic [63:0] e_dout;
    logic [15:0] e_in;
    logic [15:0] e_out;
    logic [7:0]  e_st;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic r, p, v, input logic [63:0] d,
                              input logic g0, g1, e_rdy, e_r0, e_r1,
                              input logic [63:0] e_dout,
                              input logic [15:0] e_in, e_out,
                              input logic [7:0] e_st);
    vec_t x;
    x.r = r; x.p = p; x.v = v; x.d = d; x.g0 = g0; x.g1 = g1;
    x.e_rdy = e_rdy; x.e_r0 = e_r0; x.e_r1 = e_r1; x.e_dout = e_dout;
    x.e_in = e_in; x.e_out = e_out; x.e_st = e_st;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the edge, then wait to the sampling point.
  task automatic apply(input logic r, p, v, input logic [63:0] d, input logic g0, g1);
    @(posedge clk);
    #1;
    rst         = r;
    polarity    = p;
    bus.din_vld = v;
    bus.din     = d;
    bus.gnt_0   = g0;
    bus.gnt_1   = g1;
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic rdy, r0, r1, input logic [63:0] dout);
    chk({tag, " din_rdy"}, 64'(bus.din_rdy), 64'(rdy));
    chk({tag, " req_0"},   64'(bus.req_0),   64'(r0));
    chk({tag, " req_1"},   64'(bus.req_1),   64'(r1));
    chk({tag, " dout"},    bus.dout,         dout);
  endtask

  localparam logic [63:0] P_A5 = 64'h0000_0000_0000_00A5;
  localparam logic [63:0] P_R1 = 64'h8000_0000_0000_0001;

  logic [63:0] q [$];
  logic [63:0] exp_pkt;
  logic [63:0] data;
  int          stream_err;
  int          pops;
  int          n_pkt;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; polarity = 1'b0;
    bus.din_vld = 1'b0; bus.din = '0; bus.gnt_0 = 1'b0; bus.gnt_1 = 1'b0;

    apply(0, 0, 0, 64'h0, 0, 0);
    apply(0, 1, 0, 64'h0, 0, 0);

    //             r  p  v  din            g0 g1 rdy r0 r1 dout           in out st
    tbl[0]  = mk(0, 0, 1, P_A5,          0, 0, 0, 0, 0, 64'h0,         0, 0, 0);
    tbl[1]  = mk(1, 0, 1, P_A5,          1, 0, 1, 0, 0, 64'h0,         0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 64'h0,         1, 0, 1, 1, 0, P_A5,          1, 0, 0);
    tbl[3]  = mk(1, 0, 0, 64'h0,         0, 0, 1, 0, 0, 64'h0,         1, 1, 0);
    tbl[4]  = mk(1, 0, 1, P_R1,          0, 0, 1, 0, 0, 64'h0,         1, 1, 0);
    tbl[5]  = mk(1, 1, 0, 64'h0,         1, 0, 1, 0, 1, P_R1,          2, 1, 0);
    tbl[6]  = mk(1, 1, 0, 64'h0,         1, 0, 1, 0, 1, P_R1,          2, 1, 1);
    tbl[7]  = mk(1, 1, 0, 64'h0,         0, 1, 1, 0, 1, P_R1,          2, 1, 2);
    tbl[8]  = mk(1, 0, 0, 64'h0,         0, 0, 1, 0, 0, 64'h0,         2, 2, 0);
    tbl[9]  = mk(1, 0, 1, 64'h11,        0, 0, 1, 0, 0, 64'h0,         2, 2, 0);
    tbl[10] = mk(1, 0, 1, 64'h22,        0, 0, 0, 0, 0, 64'h0,         3, 2, 0);
    tbl[11] = mk(1, 0, 1, 64'h22,        0, 0, 0, 0, 0, 64'h0,         3, 2, 0);
    tbl[12] = mk(1, 1, 1, 64'h22,        0, 0, 1, 1, 0, 64'h11,        3, 2, 0);
    tbl[13] = mk(1, 1, 1, 64'h33,        0, 0, 0, 1, 0, 64'h11,        4, 2, 1);
    tbl[14] = mk(1, 1, 0, 64'h0,         1, 0, 0, 1, 0, 64'h11,        4, 2, 2);
    tbl[15] = mk(1, 0, 0, 64'h0,         1, 0, 1, 1, 0, 64'h22,        4, 3, 0);
    tbl[16] = mk(1, 1, 0, 64'h0,         0, 0, 1, 0, 0, 64'h0,         4, 4, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i].r, tbl[i].p, tbl[i].v, tbl[i].d, tbl[i].g0, tbl[i].g1);
      chk_outs($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_dout);
      chk($sformatf("v%0d in_cnt", i),    64'(in_cnt),    64'(tbl[i].e_in));
      chk($sformatf("v%0d out_cnt", i),   64'(out_cnt),   64'(tbl[i].e_out));
      chk($sformatf("v%0d stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].e_st));
    end

    // Stall saturation: req_1 held without grant for 300 cycles.
    apply(1, 0, 1, 64'h8000_0000_0000_0005, 0, 0);
    for (int i = 0; i < 300; i++) begin
      apply(1, 1, 0, 64'h0, 1, 0);
      if (i == 254 || i == 255 || i == 299) begin
        chk($sformatf("sat stall@%0d", i), 64'(stall_cnt), 64'((i > 255) ? 255 : i));
        chk($sformatf("sat req_1@%0d", i), 64'(bus.req_1), 64'(1));
      end
    end
    apply(1, 1, 0, 64'h0, 0, 1);
    chk("sat stall before pop", 64'(stall_cnt), 64'(255));
    apply(1, 1, 0, 64'h0, 0, 0);
    chk("sat stall after pop", 64'(stall_cnt), 64'(0));
    chk("sat req_1 after pop", 64'(bus.req_1), 64'(0));
    chk("sat out_cnt", 64'(out_cnt), 64'(5));
    chk("sat in_cnt", 64'(in_cnt), 64'(5));

    // Reset with both buffers full.
    apply(1, 0, 1, 64'h0000_0000_0000_00AA, 0, 0);
    apply(1, 1, 1, 64'h8000_0000_0000_00BB, 0, 0);
    chk_outs("both full", 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_00AA);
    apply(1, 1, 1, 64'h0000_0000_0000_00CC, 0, 0);
    chk_outs("held full", 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_00AA);
    apply(0, 0, 1, 64'h0000_0000_0000_00DD, 1, 1);
    chk_outs("in reset", 1'b0, 1'b0, 1'b0, 64'h0);
    apply(1, 0, 0, 64'h0, 1, 1);
    chk_outs("post rst p0", 1'b1, 1'b0, 1'b0, 64'h0);
    chk("post rst in_cnt", 64'(in_cnt), 64'(0));
    chk("post rst out_cnt", 64'(out_cnt), 64'(0));
    chk("post rst stall_cnt", 64'(stall_cnt), 64'(0));
    apply(1, 1, 0, 64'h0, 1, 1);
    chk_outs("post rst p1", 1'b1, 1'b0, 1'b0, 64'h0);

    // Back-to-back stream wrapping both counters.
    n_pkt = 65537;
    stream_err = 0;
    pops = 0;
    q.delete();
    for (int i = 0; i < n_pkt + 2; i++) begin
      data = {1'(i[0] ^ i[4]), 31'h0, 32'(i)};
      apply(1, 1'(i & 1), (i < n_pkt) ? 1'b1 : 1'b0, data, 1, 1);
      if (bus.req_0 && bus.req_1) begin
        stream_err++;
        if (stream_err < 5) $display("FAIL stream both req at %0d", i);
      end
      if (bus.req_0 || bus.req_1) begin
        pops++;
        if (q.size() == 0) begin
          stream_err++;
          if (stream_err < 5) $display("FAIL stream pop of empty queue at %0d: dout %h", i, bus.dout);
        end else begin
          exp_pkt = q.pop_front();
          if (bus.dout !== exp_pkt || bus.req_1 !== exp_pkt[63]) begin
            stream_err++;
            if (stream_err < 5)
              $display("FAIL stream data at %0d: got %h req_1 %b expected %h", i, bus.dout, bus.req_1, exp_pkt);
          end
        end
      end
      if (i < n_pkt && bus.din_rdy !== 1'b1) begin
        stream_err++;
        if (stream_err < 5) $display("FAIL stream din_rdy low at %0d: got %b expected 1", i, bus.din_rdy);
      end
      if (bus.din_vld && bus.din_rdy) q.push_back(bus.din);
    end
    chk("stream errors", 64'(stream_err), 64'(0));
    chk("stream pops", 64'(pops), 64'(n_pkt));
    chk("stream leftover", 64'(q.size()), 64'(0));
    chk("stream in_cnt", 64'(in_cnt), 64'(1));
    chk("stream out_cnt", 64'(out_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
